// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues word fetches on the instruction bus and buffers responses for decode.
// Latency: gnt to instr_value is at least 2 cycles (response registered into the prefetch FIFO, no bypass).
// Backpressure: ready_id low holds the head; issue stops when FIFO occupancy + outstanding reaches FIFO_DEPTH.
module if_fetch_unit #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0080,
    parameter int          FIFO_DEPTH = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_F,
    input  logic        flush_F,
    input  logic [31:0] redirect_pc,
    output logic        instr_req,
    output logic [31:0] instr_addr,
    input  logic        instr_gnt,
    input  logic        instr_rvalid,
    input  logic [31:0] instr_rdata,
    input  logic        instr_err,
    input  logic        ready_id,
    output logic        instr_value,
    output logic [31:0] instr_payload,
    output logic [31:0] pc_if,
    output logic        instr_fetch_error
);

    localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW        = $clog2(FIFO_DEPTH + 2);
    localparam logic [31:0] BOOT_WORD = {BOOT_ADDR[31:2], 2'b00};

    // Fetch-side state
    logic [31:0]   fetch_addr;     // address presented on the bus
    logic [31:0]   redir_addr;     // redirect target parked behind a stalled request
    logic          redir_pend;
    logic          req_held;       // request raised last cycle and not yet granted
    logic          err_halt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [31:0]   resp_pc;        // address of the next response that will be kept

    // Prefetch FIFO
    logic [31:0]   fifo_pc  [FIFO_DEPTH];
    logic [31:0]   fifo_dat [FIFO_DEPTH];
    logic          fifo_err [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] fifo_cnt;

    logic          pop;
    logic          push;
    logic          fire;
    logic          req_stall;
    logic          issue_ok;
    logic [CW:0]   credit_use;
    logic [31:0]   redirect_word;
    logic          unused_redirect_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Instructions are word aligned; the low redirect bits carry no information
    assign unused_redirect_bits = ^redirect_pc[1:0];
    assign redirect_word        = {redirect_pc[31:2], 2'b00};

    assign pop        = instr_value & ready_id;
    // Credit: entries held + responses still in flight, minus the slot freed this cycle
    assign credit_use = {1'b0, fifo_cnt} + {1'b0, outstanding} - {{CW{1'b0}}, pop};
    assign issue_ok   = reset_n && !stall_F && !err_halt && (credit_use < (CW + 1)'(FIFO_DEPTH));
    // An ungranted request must stay up regardless of stall or flush
    assign instr_req  = req_held | issue_ok;
    assign instr_addr = fetch_addr;
    assign fire       = instr_req & instr_gnt;
    assign req_stall  = instr_req & ~instr_gnt;
    // Responses are dropped while discarding older-stream data or during the flush cycle itself
    assign push       = instr_rvalid && (discard == '0) && !flush_F;

    assign instr_value       = (fifo_cnt != '0);
    assign pc_if             = fifo_pc[rd_ptr];
    assign instr_payload     = fifo_dat[rd_ptr];
    assign instr_fetch_error = fifo_err[rd_ptr];

    // Bus address phase: hold an ungranted request, advance on grant, apply redirects after any held request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_addr <= BOOT_WORD;
            redir_addr <= BOOT_WORD;
            redir_pend <= 1'b0;
            req_held   <= 1'b0;
        end else begin
            req_held <= req_stall;
            if (fire) begin
                if (flush_F) begin
                    fetch_addr <= redirect_word;
                end else if (redir_pend) begin
                    fetch_addr <= redir_addr;
                end else begin
                    fetch_addr <= fetch_addr + 32'd4;
                end
                redir_pend <= 1'b0;
            end else if (flush_F) begin
                if (req_stall) begin
                    redir_addr <= redirect_word;
                    redir_pend <= 1'b1;
                end else begin
                    fetch_addr <= redirect_word;
                    redir_pend <= 1'b0;
                end
            end
        end
    end

    // In-flight bookkeeping: outstanding responses, stale responses to drop, and the halt after a bus error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
            discard     <= '0;
            err_halt    <= 1'b0;
            resp_pc     <= BOOT_WORD;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(instr_rvalid);
            if (flush_F) begin
                // Everything not yet returned, including a still-ungranted request, belongs to the old stream
                discard  <= outstanding + CW'(fire) - CW'(instr_rvalid) + CW'(req_stall);
                err_halt <= 1'b0;
                resp_pc  <= redirect_word;
            end else begin
                if (instr_rvalid && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    if (instr_err) begin
                        err_halt <= 1'b1;
                    end
                end
            end
        end
    end

    // FIFO pointers and occupancy; a flush empties the queue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush_F) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; reset leaves the head showing the boot address with a zero payload
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]  <= BOOT_WORD;
                fifo_dat[i] <= '0;
                fifo_err[i] <= 1'b0;
            end
        end else if (push) begin
            fifo_pc[wr_ptr]  <= resp_pc;
            fifo_dat[wr_ptr] <= instr_rdata;
            fifo_err[wr_ptr] <= instr_err;
        end
    end

    // A push into a full FIFO without a pop means the credit accounting is broken
    assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && (fifo_cnt == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a behavioural in-order instruction memory.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The memory returns addr ^ DMASK one cycle after grant unless responses are held back.
module tb_if_fetch_unit;

    localparam logic [31:0] DMASK = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        stall_F = 1'b0;
    logic        flush_F = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid = 1'b0;
    logic [31:0] instr_rdata = '0;
    logic        instr_err = 1'b0;
    logic        ready_id = 1'b1;
    logic        instr_value;
    logic [31:0] instr_payload;
    logic [31:0] pc_if;
    logic        instr_fetch_error;

    logic        gnt_en = 1'b1;
    logic        resp_hold = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFF1;
    logic        fire_s = 1'b0;
    logic [31:0] addr_s = '0;
    logic [31:0] bus_q[$];

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc;
    logic        found;
    logic        seen_err;

    always #5 clk = ~clk;

    assign instr_gnt = gnt_en;

    if_fetch_unit dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .stall_F           (stall_F),
        .flush_F           (flush_F),
        .redirect_pc       (redirect_pc),
        .instr_req         (instr_req),
        .instr_addr        (instr_addr),
        .instr_gnt         (instr_gnt),
        .instr_rvalid      (instr_rvalid),
        .instr_rdata       (instr_rdata),
        .instr_err         (instr_err),
        .ready_id          (ready_id),
        .instr_value       (instr_value),
        .instr_payload     (instr_payload),
        .pc_if             (pc_if),
        .instr_fetch_error (instr_fetch_error)
    );

    // Bus signals are stable between the input-drive point and the next rising edge
    always @(negedge clk) begin
        fire_s = instr_req && instr_gnt && reset_n;
        addr_s = instr_addr;
    end

    // In-order memory: granted addresses queue up, one response per cycle unless held
    always @(posedge clk) begin : bus_model
        logic [31:0] a;
        #2;
        if (!reset_n) begin
            bus_q.delete();
            instr_rvalid = 1'b0;
            instr_err    = 1'b0;
        end else begin
            if (fire_s) bus_q.push_back(addr_s);
            if (!resp_hold && bus_q.size() > 0) begin
                a            = bus_q.pop_front();
                instr_rvalid = 1'b1;
                instr_rdata  = a ^ DMASK;
                instr_err    = (a == err_addr);
            end else begin
                instr_rvalid = 1'b0;
                instr_err    = 1'b0;
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (instr_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", instr_req); end
        n_checks++;
        if (instr_addr !== 32'h80) begin n_fail++; $display("FAIL reset_addr: got %h want 00000080", instr_addr); end
        n_checks++;
        if (instr_value !== 1'b0) begin n_fail++; $display("FAIL reset_value: got %b want 0", instr_value); end
        n_checks++;
        if (instr_payload !== 32'h0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", instr_payload); end
        n_checks++;
        if (pc_if !== 32'h80) begin n_fail++; $display("FAIL reset_pc: got %h want 00000080", pc_if); end
        n_checks++;
        if (instr_fetch_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", instr_fetch_error); end
    endtask

    task automatic test_stream();
        @(posedge clk); #1; reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (instr_req !== 1'b1 || instr_addr !== 32'h80) begin
            n_fail++; $display("FAIL stream_first_req: req=%b addr=%h want 1/00000080", instr_req, instr_addr);
        end
        @(negedge clk);
        n_checks++;
        if (instr_value !== 1'b0) begin n_fail++; $display("FAIL stream_no_bypass: value=%b want 0", instr_value); end
        exp_pc = 32'h80;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (instr_value !== 1'b1 || pc_if !== exp_pc || instr_payload !== (exp_pc ^ DMASK) || instr_fetch_error !== 1'b0) begin
                n_fail++; $display("FAIL stream_seq[%0d]: value=%b pc=%h payload=%h err=%b want 1 %h %h 0",
                                   i, instr_value, pc_if, instr_payload, instr_fetch_error, exp_pc, exp_pc ^ DMASK);
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1; ready_id = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (instr_value !== 1'b1 || pc_if !== exp_pc || instr_payload !== (exp_pc ^ DMASK)) begin
                n_fail++; $display("FAIL bp_hold[%0d]: value=%b pc=%h payload=%h want 1 %h %h",
                                   i, instr_value, pc_if, instr_payload, exp_pc, exp_pc ^ DMASK);
            end
            if (i >= 6) begin
                n_checks++;
                if (instr_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_drop[%0d]: req=%b want 0", i, instr_req); end
            end
        end
        @(posedge clk); #1; ready_id = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (instr_value !== 1'b1 || pc_if !== exp_pc || instr_payload !== (exp_pc ^ DMASK)) begin
                n_fail++; $display("FAIL bp_resume[%0d]: value=%b pc=%h payload=%h want 1 %h %h",
                                   i, instr_value, pc_if, instr_payload, exp_pc, exp_pc ^ DMASK);
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_gnt_low_flush();
        @(posedge clk); #1; reset_n = 1'b0; gnt_en = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            flush_F     = (i == 1);
            redirect_pc = 32'h203;
            @(negedge clk);
            n_checks++;
            if (instr_req !== 1'b1 || instr_addr !== 32'h80 || instr_value !== 1'b0) begin
                n_fail++; $display("FAIL gnt_low_hold[%0d]: req=%b addr=%h value=%b want 1 00000080 0",
                                   i, instr_req, instr_addr, instr_value);
            end
        end
        @(posedge clk); #1; flush_F = 1'b0; gnt_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (instr_req !== 1'b1 || instr_addr !== 32'h80) begin
            n_fail++; $display("FAIL gnt_low_complete: req=%b addr=%h want 1 00000080", instr_req, instr_addr);
        end
        @(negedge clk);
        n_checks++;
        if (instr_addr !== 32'h200) begin n_fail++; $display("FAIL gnt_low_redirect_addr: addr=%h want 00000200", instr_addr); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = instr_value;
        end
        n_checks++;
        if (!found || pc_if !== 32'h200 || instr_payload !== (32'h200 ^ DMASK)) begin
            n_fail++; $display("FAIL gnt_low_first_pc: found=%b pc=%h payload=%h want 1 00000200 %h",
                               found, pc_if, instr_payload, 32'h200 ^ DMASK);
        end
        exp_pc = 32'h204;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (instr_value !== 1'b1 || pc_if !== exp_pc) begin
                n_fail++; $display("FAIL gnt_low_seq[%0d]: value=%b pc=%h want 1 %h", i, instr_value, pc_if, exp_pc);
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_flush_outstanding();
        @(posedge clk); #1; resp_hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (instr_value) begin
                n_checks++;
                if (pc_if !== exp_pc) begin n_fail++; $display("FAIL fo_drain[%0d]: pc=%h want %h", i, pc_if, exp_pc); end
                exp_pc += 32'd4;
            end
        end
        n_checks++;
        if (instr_req !== 1'b0 || instr_value !== 1'b0) begin
            n_fail++; $display("FAIL fo_credit_cap: req=%b value=%b want 0 0", instr_req, instr_value);
        end
        @(posedge clk); #1; resp_hold = 1'b0; flush_F = 1'b1; redirect_pc = 32'h400;
        @(posedge clk); #1; flush_F = 1'b0;
        @(negedge clk);
        n_checks++;
        if (instr_value !== 1'b0 || instr_req !== 1'b1 || instr_addr !== 32'h400) begin
            n_fail++; $display("FAIL fo_after_flush: value=%b req=%b addr=%h want 0 1 00000400", instr_value, instr_req, instr_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = instr_value;
        end
        n_checks++;
        if (!found || pc_if !== 32'h400 || instr_payload !== (32'h400 ^ DMASK)) begin
            n_fail++; $display("FAIL fo_first_pc: found=%b pc=%h payload=%h want 1 00000400 %h",
                               found, pc_if, instr_payload, 32'h400 ^ DMASK);
        end
        exp_pc = 32'h404;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (instr_value !== 1'b1 || pc_if !== exp_pc) begin
                n_fail++; $display("FAIL fo_seq[%0d]: value=%b pc=%h want 1 %h", i, instr_value, pc_if, exp_pc);
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_error();
        @(posedge clk); #1; reset_n = 1'b0; err_addr = 32'h90;
        repeat (2) @(posedge clk);
        #1; reset_n = 1'b1;
        exp_pc   = 32'h80;
        seen_err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (instr_value) begin
                n_checks++;
                if (pc_if !== exp_pc || instr_fetch_error !== (exp_pc == 32'h90) || instr_payload !== (exp_pc ^ DMASK)) begin
                    n_fail++; $display("FAIL err_seq[%0d]: pc=%h err=%b payload=%h want %h %b %h",
                                       i, pc_if, instr_fetch_error, instr_payload, exp_pc, exp_pc == 32'h90, exp_pc ^ DMASK);
                end
                if (exp_pc == 32'h90) seen_err = 1'b1;
                exp_pc += 32'd4;
            end
            if (i >= 12) begin
                n_checks++;
                if (instr_req !== 1'b0) begin n_fail++; $display("FAIL err_halt_req[%0d]: req=%b want 0", i, instr_req); end
            end
        end
        n_checks++;
        if (seen_err !== 1'b1 || instr_value !== 1'b0) begin
            n_fail++; $display("FAIL err_delivered: seen_0x90=%b value=%b want 1 0", seen_err, instr_value);
        end
    endtask

    task automatic test_wrap_and_reset();
        @(posedge clk); #1; flush_F = 1'b1; redirect_pc = 32'hFFFF_FFF8; err_addr = 32'hFFFF_FFF1;
        @(posedge clk); #1; flush_F = 1'b0;
        @(negedge clk);
        n_checks++;
        if (instr_req !== 1'b1 || instr_addr !== 32'hFFFF_FFF8) begin
            n_fail++; $display("FAIL wrap_restart: req=%b addr=%h want 1 fffffff8", instr_req, instr_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = instr_value;
        end
        n_checks++;
        if (!found || pc_if !== 32'hFFFF_FFF8) begin
            n_fail++; $display("FAIL wrap_first: found=%b pc=%h want 1 fffffff8", found, pc_if);
        end
        exp_pc = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (instr_value !== 1'b1 || pc_if !== exp_pc || instr_payload !== (exp_pc ^ DMASK)) begin
                n_fail++; $display("FAIL wrap_seq[%0d]: value=%b pc=%h payload=%h want 1 %h %h",
                                   i, instr_value, pc_if, instr_payload, exp_pc, exp_pc ^ DMASK);
            end
            exp_pc += 32'd4;
        end
        @(posedge clk); #1; reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (instr_req !== 1'b0 || instr_value !== 1'b0 || instr_addr !== 32'h80 || pc_if !== 32'h80 ||
            instr_payload !== 32'h0 || instr_fetch_error !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: req=%b value=%b addr=%h pc=%h payload=%h err=%b want 0 0 00000080 00000080 0 0",
                               instr_req, instr_value, instr_addr, pc_if, instr_payload, instr_fetch_error);
        end
        @(posedge clk);
        @(posedge clk); #1; reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (instr_req !== 1'b1 || instr_addr !== 32'h80) begin
            n_fail++; $display("FAIL midreset_restart: req=%b addr=%h want 1 00000080", instr_req, instr_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = instr_value;
        end
        n_checks++;
        if (!found || pc_if !== 32'h80 || instr_payload !== (32'h80 ^ DMASK)) begin
            n_fail++; $display("FAIL midreset_first_pc: found=%b pc=%h payload=%h want 1 00000080 %h",
                               found, pc_if, instr_payload, 32'h80 ^ DMASK);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_low_flush();
        test_flush_outstanding();
        test_error();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
